// File: rtl/dist_ram_fifo_ctrl_pkg.sv
// rtl/dist_ram_fifo_ctrl_pkg.sv - shared sizing for the distributed-RAM FIFO controller
package dist_ram_fifo_ctrl_pkg;

    localparam int AW_DEFAULT = 5;

    typedef logic [AW_DEFAULT-1:0] ptr_t;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/dist_ram_fifo_ctrl.sv
// rtl/dist_ram_fifo_ctrl.sv - FWFT pointer/flag controller driving a bank of 32x1 dual-port RAMs
module dist_ram_fifo_ctrl
    import dist_ram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    ram_a,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_d,
    output logic [AW-1:0]    ram_dpra,
    input  logic [WIDTH-1:0] ram_dpo,
    output logic [AW:0]      level
);

    localparam int          DEPTH   = fifo_depth(AW);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      ram_cnt_q, ram_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             wr, ld;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // Full blocks writes even when a load frees a slot this cycle, so the
        // write address can never equal the read address being loaded.
        in_ready = resetb && (ram_cnt_q != DEPTH_C);
        wr       = in_valid && in_ready;
        ld       = (ram_cnt_q != '0) && (!out_valid_q || out_ready);

        if (wr) begin
            wptr_d = wptr_q + 1'b1;
        end

        if (ld) begin
            out_data_d  = ram_dpo;
            out_valid_d = 1'b1;
            rptr_d      = rptr_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case ({wr, ld})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ram_we    = wr;
    assign ram_d     = in_data;
    assign ram_a     = wptr_q;
    assign ram_dpra  = rptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign level     = ram_cnt_q + {{AW{1'b0}}, out_valid_q};

endmodule
